pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit. It is the next generation of the team's single-cycle full adder.
- Splits a WIDTH-bit operation into STAGES equal chunks and computes one chunk per clock. The carry is registered between stages.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake with back-pressure.
- Sits between producer and consumer datapaths that need high Fmax on wide arithmetic.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin. In this mode cout=1 means no borrow.
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is b after the optional inversion.
- Pipeline: stage k (0-based) adds bits [k*CW +: CW] of a and B' plus the carry registered from stage k-1.
  - Stage 0 carry-in is cin, or ~cin when sub=1.
  - Unprocessed upper operand chunks and completed lower sum chunks are carried forward in stage registers.
  - Each stage has its own valid bit.
- Latency: a beat accepted on cycle N appears on sum/cout/ovf with out_valid=1 at cycle N+STAGES, provided there is no stall. Throughput is one beat per cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_ready and registered out_valid.
  - During a stall every stage register, including its valid bit, holds. Outputs stay stable until the transfer completes.
  - A beat presented while in_ready=0 is not captured. The producer must hold it.
- Bubbles: stage valid bits are 0 when no input was accepted. Bubbles propagate and are not compacted. out_valid=0 produces no transfer regardless of out_ready.
- Simultaneous events: when the output transfers and a new input is accepted in the same cycle, the pipeline advances normally with no lost or duplicated beat.
- Reset (rst_n=0 sampled at posedge):
  - All stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 while out_valid=0.
  - Reset mid-operation discards all in-flight beats. The first input accepted after rst_n returns high emerges STAGES cycles later.
- STAGES=1: degenerates to a single registered adder with latency 1.
- STAGES=WIDTH: the ripple carry is fully pipelined (CW=1).
- Boundary values:
  - All-ones + 1 wraps sum to 0 with cout=1.
  - Subtracting equal operands with cin=0 gives sum=0, cout=1.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=0xFF, b=0x01, cin=0, sub=0 -> after 2 cycles, sum=0x00, cout=1, ovf=0.
- Same config: a=0x7F, b=0x01, add -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x01, sub=1, cin=0 -> sum=0x7F, cout=1, ovf=1.
- Subtract with borrow: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0, ovf=0. Same with cin=1 -> sum=0xFD.
- Back-pressure: stream 6 back-to-back beats and drop out_ready for 3 cycles after the 2nd result. Required: in_ready=0 during the stall, outputs held stable, all 6 results in order with no loss or duplication.
- Reset mid-flight: accept 2 beats, assert rst_n=0 for 1 cycle. Required: next cycle out_valid=0, sum=0, and neither beat ever appears. A new beat after release appears 2 cycles later.
- Random and reference check, for WIDTH=32/STAGES=4 and WIDTH=8/STAGES=8: 10k random beats with random in_valid/out_ready. Every output {cout,sum} and ovf must match the behavioural model of the accepted beat, in order.

Source files
------------

// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//
// Purpose:
//   Pipelined add/subtract unit. A WIDTH-bit operation is split into STAGES
//   equal chunks of CW = WIDTH/STAGES bits, and one chunk is resolved per
//   clock. The ripple carry is registered between stages. The unit supports a
//   subtract mode and reports a two's-complement overflow flag. A valid/ready
//   handshake with back-pressure surrounds the pipeline.
//
// Parameters:
//   WIDTH   operand/result width in bits (must be a multiple of STAGES)
//   STAGES  number of pipeline stages, 1..WIDTH
//
// Ports:
//   i_clk        clock, every state update happens on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   operand beat valid
//   o_in_ready   unit can accept a beat this cycle
//   i_a, i_b     operands (unsigned or two's complement)
//   i_cin        carry-in for add, borrow-in for subtract
//   i_sub        0 = a + b + cin, 1 = a - b - cin
//   o_out_valid  result beat valid
//   i_out_ready  consumer accepts the result this cycle
//   o_sum        result
//   o_cout       raw carry out of the MSB (1 = no borrow when subtracting)
//   o_ovf        two's-complement overflow
// ---------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers. Each stage keeps both whole operands because the upper
  // chunks are still needed downstream and the operand MSBs feed the overflow
  // flag. The sum vector fills in from the bottom, one chunk per stage. The
  // B operand is stored already inverted for subtraction.
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];
  logic             r_valid [STAGES];

  logic [WIDTH-1:0] w_aIn      [STAGES];
  logic [WIDTH-1:0] w_bIn      [STAGES];
  logic [WIDTH-1:0] w_sumIn    [STAGES];
  logic [WIDTH-1:0] w_sumNext  [STAGES];
  logic             w_cIn      [STAGES];
  logic             w_vIn      [STAGES];
  logic [CW:0]      w_chunk    [STAGES];
  logic             w_stall;

  // A result that is valid but not taken freezes the whole pipeline. No
  // bubbles are squeezed out. That keeps ready a single gate away from the
  // registered out_valid and the consumer's ready.
  assign w_stall    = r_valid[LAST] & ~i_out_ready;
  assign o_in_ready = ~w_stall;

  // Build each stage's inputs and its chunk addition. Stage 0 takes operands
  // straight from the ports. Subtraction is folded in here as a + ~b + ~cin,
  // so every later stage is a plain adder. Each following stage takes the
  // registered state of the stage before it.
  always_comb begin
    w_aIn[0]   = i_a;
    w_bIn[0]   = i_b ^ {WIDTH{i_sub}};
    w_cIn[0]   = i_cin ^ i_sub;
    w_sumIn[0] = '0;
    w_vIn[0]   = i_in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_aIn[k]   = r_a[k-1];
      w_bIn[k]   = r_b[k-1];
      w_cIn[k]   = r_carry[k-1];
      w_sumIn[k] = r_sum[k-1];
      w_vIn[k]   = r_valid[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k] = {1'b0, w_aIn[k][k*CW +: CW]}
                 + {1'b0, w_bIn[k][k*CW +: CW]}
                 + {{CW{1'b0}}, w_cIn[k]};
      w_sumNext[k] = w_sumIn[k];
      w_sumNext[k][k*CW +: CW] = w_chunk[k][CW-1:0];
    end
  end

  // Advance every stage together unless the output is stalled. Reset clears
  // all state, not only the valid bits. This way the outputs read as zero
  // straight after reset and any in-flight beat is discarded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
        r_valid[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]     <= w_aIn[k];
        r_b[k]     <= w_bIn[k];
        r_sum[k]   <= w_sumNext[k];
        r_carry[k] <= w_chunk[k][CW];
        r_valid[k] <= w_vIn[k];
      end
    end
  end

  // Overflow uses the already-inverted B held in the last stage. With all
  // registers at zero after reset, this expression also reads zero.
  assign o_out_valid = r_valid[LAST];
  assign o_sum       = r_sum[LAST];
  assign o_cout      = r_carry[LAST];
  assign o_ovf       = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1])
                     && (r_sum[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Purpose:
//   Self-checking bench for pipelined_addsub. Three instances are exercised:
//   8-bit/2-stage for directed cases, and 32-bit/4-stage plus 8-bit/8-stage
//   for long random handshake runs. The instances share operand and
//   out_ready drivers, but each has its own in_valid. Every accepted beat is
//   run through an arithmetic reference model, and the expected result is
//   queued. Each output transfer is compared against the head of that
//   instance's queue.
// ---------------------------------------------------------------------------
module tb_pipelined_addsub;

  localparam int NBEATS = 10000;
  localparam int BUDGET = 40000;

  logic        clock;
  logic        resetN;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        outReady;

  logic        inValid8x2,  inReady8x2,  outValid8x2,  cout8x2,  ovf8x2;
  logic        inValid32x4, inReady32x4, outValid32x4, cout32x4, ovf32x4;
  logic        inValid8x8,  inReady8x8,  outValid8x8,  cout8x8,  ovf8x8;
  logic [7:0]  sum8x2;
  logic [31:0] sum32x4;
  logic [7:0]  sum8x8;

  logic [33:0] q8x2[$];
  logic [33:0] q32x4[$];
  logic [33:0] q8x8[$];

  int  errCount   = 0;
  int  checkCount = 0;
  int  xf8x2 = 0, xf32x4 = 0, xf8x8 = 0;
  bit  acc8x2, acc32x4, acc8x8;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u8x2 (
    .i_clk(clock), .i_rst_n(resetN), .i_in_valid(inValid8x2), .o_in_ready(inReady8x2),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_cin(cin), .i_sub(sub),
    .o_out_valid(outValid8x2), .i_out_ready(outReady),
    .o_sum(sum8x2), .o_cout(cout8x2), .o_ovf(ovf8x2)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u32x4 (
    .i_clk(clock), .i_rst_n(resetN), .i_in_valid(inValid32x4), .o_in_ready(inReady32x4),
    .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
    .o_out_valid(outValid32x4), .i_out_ready(outReady),
    .o_sum(sum32x4), .o_cout(cout32x4), .o_ovf(ovf32x4)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(8)) u8x8 (
    .i_clk(clock), .i_rst_n(resetN), .i_in_valid(inValid8x8), .o_in_ready(inReady8x8),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_cin(cin), .i_sub(sub),
    .o_out_valid(outValid8x8), .i_out_ready(outReady),
    .o_sum(sum8x8), .o_cout(cout8x8), .o_ovf(ovf8x8)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something upstream never terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result in the form {ovf, cout, sum[31:0]}, computed with plain
  // integer arithmetic. The carry comes from the full-precision sum. Overflow
  // means the true signed result a +/- b +/- cin falls outside the w-bit
  // signed range.
  function automatic logic [33:0] refModel(input longint unsigned av, input longint unsigned bv,
                                           input bit c, input bit s, input int w);
    longint unsigned mask;
    longint unsigned total;
    longint          sa, sb, r, lim;
    bit              o;
    mask  = (longint'(1) << w) - 1;
    av    = av & mask;
    bv    = bv & mask;
    total = s ? (av + (~bv & mask) + (c ? 0 : 1)) : (av + bv + c);
    lim   = longint'(1) << (w - 1);
    sa    = (av >= lim) ? longint'(av) - (lim << 1) : longint'(av);
    sb    = (bv >= lim) ? longint'(bv) - (lim << 1) : longint'(bv);
    r     = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
    o     = (r < -lim) || (r > lim - 1);
    return {o, 1'(total >> w), 32'(total & mask)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: at the falling edge, decide which transfers the next rising
  // edge will perform. Accepted inputs are pushed to the model queues, and
  // transferred outputs are checked. Then step to just past the rising edge.
  // A reset edge discards everything in flight.
  task automatic stepCycle();
    @(negedge clock);
    acc8x2 = 0; acc32x4 = 0; acc8x8 = 0;
    if (!resetN) begin
      q8x2.delete(); q32x4.delete(); q8x8.delete();
    end else begin
      if (inValid8x2 && inReady8x2) begin
        q8x2.push_back(refModel(64'(a), 64'(b), cin, sub, 8)); acc8x2 = 1;
      end
      if (inValid32x4 && inReady32x4) begin
        q32x4.push_back(refModel(64'(a), 64'(b), cin, sub, 32)); acc32x4 = 1;
      end
      if (inValid8x8 && inReady8x8) begin
        q8x8.push_back(refModel(64'(a), 64'(b), cin, sub, 8)); acc8x8 = 1;
      end
      if (outValid8x2 && outReady) begin
        xf8x2++;
        checkOutput("8x2 beat pending", 64'(q8x2.size() != 0), 64'(1));
        if (q8x2.size() != 0)
          checkOutput("8x2 result", 64'({ovf8x2, cout8x2, 24'h0, sum8x2}), 64'(q8x2.pop_front()));
      end
      if (outValid32x4 && outReady) begin
        xf32x4++;
        checkOutput("32x4 beat pending", 64'(q32x4.size() != 0), 64'(1));
        if (q32x4.size() != 0)
          checkOutput("32x4 result", 64'({ovf32x4, cout32x4, sum32x4}), 64'(q32x4.pop_front()));
      end
      if (outValid8x8 && outReady) begin
        xf8x8++;
        checkOutput("8x8 beat pending", 64'(q8x8.size() != 0), 64'(1));
        if (q8x8.size() != 0)
          checkOutput("8x8 result", 64'({ovf8x8, cout8x8, 24'h0, sum8x8}), 64'(q8x8.pop_front()));
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Present one beat to the 8x2 instance for a single cycle with the
  // consumer ready, then withdraw it.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input bit c, input bit s);
    a = {24'h0, av}; b = {24'h0, bv}; cin = c; sub = s;
    outReady = 1'b1;
    inValid8x2 = 1'b1;
    stepCycle();
    inValid8x2 = 1'b0;
  endtask

  // Apply a directed beat and check that the result is valid exactly two
  // cycles later. The compared value is {out_valid, ovf, cout, sum}.
  task automatic directedCase(input string tag, input logic [7:0] av, input logic [7:0] bv,
                              input bit c, input bit s, input logic [10:0] expected);
    applyStimulus(av, bv, c, s);
    #1;
    checkOutput({tag, " not early"}, 64'(outValid8x2), 64'(0));
    stepCycle();
    #1;
    checkOutput(tag, 64'({outValid8x2, ovf8x2, cout8x2, sum8x2}), 64'(expected));
  endtask

  function automatic bit accOf(input int sel);
    return (sel == 0) ? acc32x4 : acc8x8;
  endfunction

  function automatic int xfOf(input int sel);
    return (sel == 0) ? xf32x4 : xf8x8;
  endfunction

  function automatic int qSize(input int sel);
    return (sel == 0) ? q32x4.size() : q8x8.size();
  endfunction

  task automatic setValid(input int sel, input bit v);
    if (sel == 0) inValid32x4 = v;
    else          inValid8x8  = v;
  endtask

  // Random run on one instance. The producer holds a beat until it is
  // accepted. in_valid and out_ready both toggle randomly. Corner operands
  // (all-ones, equal operands) are mixed in.
  task automatic runRandom(input int sel, input string tag);
    int accepted = 0;
    int cycles   = 0;
    bit pend     = 0;
    int xfStart  = xfOf(sel);
    while (accepted < NBEATS && cycles < BUDGET) begin
      if (!pend && $urandom_range(3) != 0) begin
        a   = $urandom;
        b   = $urandom;
        if ($urandom_range(7) == 0) a = '1;
        if ($urandom_range(7) == 0) b = a;
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
        pend = 1;
      end
      setValid(sel, pend);
      outReady = ($urandom_range(3) != 0);
      stepCycle();
      if (accOf(sel)) begin
        pend = 0;
        accepted++;
      end
      cycles++;
    end
    setValid(sel, 1'b0);
    outReady = 1'b1;
    repeat (12) stepCycle();
    checkOutput({tag, " beats accepted"}, 64'(accepted), 64'(NBEATS));
    checkOutput({tag, " beats delivered"}, 64'(xfOf(sel) - xfStart), 64'(accepted));
    checkOutput({tag, " nothing left in flight"}, 64'(qSize(sel)), 64'(0));
  endtask

  initial begin
    int          idx;
    int          xfStart;
    int          stallLeft;
    bit          stallStarted;
    logic [10:0] held;

    resetN = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; outReady = 1'b1;
    inValid8x2 = 1'b0; inValid32x4 = 1'b0; inValid8x8 = 1'b0;
    repeat (3) stepCycle();
    resetN = 1'b1;
    #1;

    // Reset state.
    checkOutput("reset 8x2 outputs", 64'({outValid8x2, ovf8x2, cout8x2, sum8x2}), 64'(0));
    checkOutput("reset 8x2 in_ready", 64'(inReady8x2), 64'(1));
    checkOutput("reset 32x4 outputs", 64'({outValid32x4, ovf32x4, cout32x4, sum32x4}), 64'(0));
    checkOutput("reset 8x8 outputs", 64'({outValid8x8, ovf8x8, cout8x8, sum8x8}), 64'(0));

    // Directed arithmetic on the 8-bit, 2-stage unit.
    directedCase("all-ones plus one", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
    directedCase("add overflow",      8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b1, 1'b0, 8'h80});
    directedCase("sub overflow",      8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 1'b1, 8'h7F});
    directedCase("sub borrow",        8'h05, 8'h07, 1'b0, 1'b1, {1'b1, 1'b0, 1'b0, 8'hFE});
    directedCase("sub borrow-in",     8'h05, 8'h07, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 8'hFD});
    directedCase("sub equal",         8'h5A, 8'h5A, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 8'h00});
    directedCase("add carry-in",      8'h0F, 8'h10, 1'b1, 1'b0, {1'b1, 1'b0, 1'b0, 8'h20});
    repeat (2) stepCycle();

    // Back-pressure: six back-to-back beats. After the second result is
    // taken, the consumer stalls for three cycles.
    idx = 0; stallLeft = 0; stallStarted = 0; held = '0;
    xfStart = xf8x2;
    for (int cyc = 0; cyc < 40 && (xf8x2 - xfStart) < 6; cyc++) begin
      if (acc8x2) idx++;
      inValid8x2 = (idx < 6);
      a   = 32'(8'h10 * idx + 3);
      b   = 32'(8'h21 + idx);
      sub = idx[0];
      cin = idx[1];
      if (!stallStarted && (xf8x2 - xfStart) == 2) begin
        stallStarted = 1;
        stallLeft    = 3;
      end
      outReady = (stallLeft == 0);
      #1;
      if (stallLeft > 0) begin
        checkOutput("stall in_ready low", 64'(inReady8x2), 64'(0));
        if (stallLeft == 3)
          held = {outValid8x2, ovf8x2, cout8x2, sum8x2};
        else
          checkOutput("stall outputs held", 64'({outValid8x2, ovf8x2, cout8x2, sum8x2}), 64'(held));
        stallLeft--;
      end
      stepCycle();
    end
    inValid8x2 = 1'b0;
    outReady   = 1'b1;
    checkOutput("stall results delivered", 64'(xf8x2 - xfStart), 64'(6));
    checkOutput("stall stall seen", 64'(stallStarted), 64'(1));
    repeat (3) stepCycle();

    // Reset mid-flight. Two beats are accepted while the consumer is not
    // ready, then reset is pulsed for one cycle.
    xfStart  = xf8x2;
    outReady = 1'b0;
    a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0;
    inValid8x2 = 1'b1;
    stepCycle();
    a = 32'h33; b = 32'h44;
    stepCycle();
    inValid8x2 = 1'b0;
    resetN = 1'b0;
    stepCycle();
    resetN = 1'b1;
    #1;
    checkOutput("mid-reset outputs cleared", 64'({outValid8x2, ovf8x2, cout8x2, sum8x2}), 64'(0));
    checkOutput("mid-reset in_ready", 64'(inReady8x2), 64'(1));
    outReady = 1'b1;
    repeat (3) begin
      stepCycle();
      #1;
      checkOutput("mid-reset no stale beat", 64'(outValid8x2), 64'(0));
    end
    checkOutput("mid-reset nothing delivered", 64'(xf8x2 - xfStart), 64'(0));
    directedCase("after reset", 8'h12, 8'h34, 1'b0, 1'b0, {1'b1, 1'b0, 1'b0, 8'h46});
    repeat (2) stepCycle();

    // Long random runs on the wide and the fully pipelined configurations.
    runRandom(0, "random 32x4");
    runRandom(1, "random 8x8");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
